cdb_arbiter: RTL and testbench

//  Producer side of the common data bus. Collects (ROBEN, result) pairs from NUM_SRC functional units
//  (ALU, memory unit, future mul/div) and drives the two CDB broadcast ports consumed by ROB, RS and LdStBuffer.
//  Per-source FIFOs absorb contention; round-robin picks up to two winners per cycle; ROB flush drains all state.

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_src_fifo.sv | 68 ++++++
 rtl/cdb_arbiter.sv | 138 +++++++++++++
 tb/tb_cdb_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared common-data-bus definitions used by the CDB producer side and its consumers (ROB, RS, LdStBuffer).
package cdb_arbiter_pkg;

  localparam int CDB_ROBEN_W     = 5;
  localparam int CDB_DATA_W      = 32;
  localparam int NUM_SRC_DFLT    = 4;
  localparam int FIFO_DEPTH_DFLT = 2;

  // Tag value meaning "nothing on this CDB port".
  localparam logic [CDB_ROBEN_W-1:0] ROBEN_NONE = '0;

  // Wraps idx (known to be < 2*n) back into 0..n-1 without a divider.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue feeding the CDB arbiter: holds (ROBEN, data) pairs, exposes the head,
// and supports simultaneous push/pop plus a synchronous flush that wins over both.
module cdb_src_fifo #(
  parameter int DEPTH   = 2,
  parameter int ROBEN_W = 5,
  parameter int DATA_W  = 32,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ROBEN_W-1:0] push_roben,
  input  logic [DATA_W-1:0]  push_data,
  output logic [ROBEN_W-1:0] head_roben,
  output logic [DATA_W-1:0]  head_data,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               full
);

  logic [AW-1:0]      rd_q, wr_q;
  logic [CW-1:0]      cnt_q;
  logic [ROBEN_W-1:0] mem_roben [DEPTH];
  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic               push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign head_roben = mem_roben[rd_q];
  assign head_data  = mem_data[rd_q];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_roben[wr_q] <= push_roben;
      mem_data[wr_q]  <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Producer side of the common data bus: per-source FIFOs, a two-winner round-robin picker
// and registered CDB broadcast ports, all cleared by ROB flush.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT,
  parameter int ROBEN_W    = CDB_ROBEN_W,
  parameter int DATA_W     = CDB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*ROBEN_W-1:0] src_roben,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [ROBEN_W-1:0]         cdb_roben1,
  output logic [DATA_W-1:0]          cdb_data1,
  output logic [ROBEN_W-1:0]         cdb_roben2,
  output logic [DATA_W-1:0]          cdb_data2,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0] push, pop, empty, full;
  logic [ROBEN_W-1:0] head_roben [NUM_SRC];
  logic [DATA_W-1:0]  head_data  [NUM_SRC];
  logic [CW-1:0]      count      [NUM_SRC];

  logic [IW-1:0]      rr_q, rr_d, g1_idx, g2_idx, last_idx;
  logic               g1_vld, g2_vld;
  logic [ROBEN_W-1:0] roben1_q, roben1_d, roben2_q, roben2_d;
  logic [DATA_W-1:0]  data1_q, data1_d, data2_q, data2_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Tag 0 means "no result" and is never queued.
    assign push[i]      = src_valid[i] & src_ready[i] &
                          (src_roben[i*ROBEN_W +: ROBEN_W] != ROBEN_W'(0));
    assign src_ready[i] = ~full[i];

    cdb_src_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .ROBEN_W (ROBEN_W),
      .DATA_W  (DATA_W)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (push[i]),
      .pop        (pop[i]),
      .push_roben (src_roben[i*ROBEN_W +: ROBEN_W]),
      .push_data  (src_data[i*DATA_W +: DATA_W]),
      .head_roben (head_roben[i]),
      .head_data  (head_data[i]),
      .count      (count[i]),
      .empty      (empty[i]),
      .full       (full[i])
    );
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    g1_vld = 1'b0;
    g2_vld = 1'b0;
    g1_idx = '0;
    g2_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_wrap(int'(rr_q) + k, NUM_SRC);
      if (!empty[idx]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = IW'(idx);
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2_idx = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    pop      = '0;
    roben1_d = '0;
    data1_d  = '0;
    roben2_d = '0;
    data2_d  = '0;
    rr_d     = rr_q;
    last_idx = g2_vld ? g2_idx : g1_idx;
    if (g1_vld) begin
      pop[g1_idx] = 1'b1;
      roben1_d    = head_roben[g1_idx];
      data1_d     = head_data[g1_idx];
      rr_d        = (last_idx == IW'(NUM_SRC - 1)) ? '0 : last_idx + IW'(1);
    end
    if (g2_vld) begin
      pop[g2_idx] = 1'b1;
      roben2_d    = head_roben[g2_idx];
      data2_d     = head_data[g2_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q     <= '0;
      roben1_q <= '0;
      data1_q  <= '0;
      roben2_q <= '0;
      data2_q  <= '0;
    end else if (flush) begin
      rr_q     <= '0;
      roben1_q <= '0;
      data1_q  <= '0;
      roben2_q <= '0;
      data2_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      roben1_q <= roben1_d;
      data1_q  <= data1_d;
      roben2_q <= roben2_d;
      data2_q  <= data2_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) busy = busy | (count[i] != '0);
  end

  assign cdb_roben1 = roben1_q;
  assign cdb_data1  = data1_q;
  assign cdb_roben2 = roben2_q;
  assign cdb_data2  = data2_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized self-checking bench for cdb_arbiter with default parameters.
module tb_cdb_arbiter;

  localparam int NS = 4;
  localparam int RW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NS-1:0]    src_valid;
  logic [NS*RW-1:0] src_roben;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_ready;
  logic [RW-1:0]    cdb_roben1, cdb_roben2;
  logic [DW-1:0]    cdb_data1, cdb_data2;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int outstanding [32];
  int pend        [32];

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_roben  (src_roben),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .cdb_roben1 (cdb_roben1),
    .cdb_data1  (cdb_data1),
    .cdb_roben2 (cdb_roben2),
    .cdb_data2  (cdb_data2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [4:0] tag);
    return 32'hC0DE_0000 | {27'd0, tag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] tag);
    src_valid[i]           = 1'b1;
    src_roben[i*RW +: RW]  = tag;
    src_data[i*DW +: DW]   = dat(tag);
  endtask

  task automatic clr_src();
    src_valid = '0;
    src_roben = '0;
    src_data  = '0;
  endtask

  task automatic expect_ports(input string tag, input logic [4:0] t1, input logic [4:0] t2);
    check({tag, "_r1"}, cdb_roben1, t1);
    check({tag, "_d1"}, cdb_data1, (t1 == 0) ? 32'd0 : dat(t1));
    check({tag, "_r2"}, cdb_roben2, t2);
    check({tag, "_d2"}, cdb_data2, (t2 == 0) ? 32'd0 : dat(t2));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic score(input logic [4:0] t, input logic [31:0] d);
    if (t != 0) begin
      check("rnd_live", outstanding[t] > 0, 1'b1);
      check("rnd_data", d, dat(t));
      if (outstanding[t] > 0) outstanding[t]--;
    end else begin
      check("rnd_idle_data", d, 32'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    clr_src();
    for (int k = 0; k < 32; k++) outstanding[k] = 0;
    #2;
    check("rst_r1", cdb_roben1, 0);
    check("rst_r2", cdb_roben2, 0);
    check("rst_d1", cdb_data1, 0);
    check("rst_d2", cdb_data2, 0);
    check("rst_ready", src_ready, 4'hF);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;

    // Single source: write edge, then broadcast edge, then idle.
    src_valid[0]        = 1'b1;
    src_roben[0 +: RW]  = 5'd3;
    src_data[0 +: DW]   = 32'h1234;
    tick();
    clr_src();
    check("single_wait_r1", cdb_roben1, 0);
    check("single_wait_busy", busy, 1);
    tick();
    check("single_r1", cdb_roben1, 3);
    check("single_d1", cdb_data1, 32'h1234);
    check("single_r2", cdb_roben2, 0);
    check("single_busy", busy, 0);
    tick();
    check("single_idle_r1", cdb_roben1, 0);

    // Contention from rr_ptr = 0.
    do_flush();
    for (int i = 0; i < NS; i++) set_src(i, 5'(i + 1));
    tick();
    clr_src();
    tick();
    expect_ports("cont_a", 1, 2);
    tick();
    expect_ports("cont_b", 3, 4);
    tick();
    expect_ports("cont_idle", 0, 0);
    // rr_ptr must be back at 0: src0 wins port 1 over src3.
    set_src(0, 5'd8);
    set_src(3, 5'd9);
    tick();
    clr_src();
    tick();
    expect_ports("cont_rr0", 8, 9);

    // Backpressure on src1 while src0/src2/src3 keep the ports busy.
    do_flush();
    set_src(0, 5'd1);
    set_src(1, 5'd2);
    tick();
    clr_src();
    set_src(0, 5'd5);
    set_src(1, 5'd6);
    set_src(2, 5'd3);
    set_src(3, 5'd4);
    tick();
    clr_src();
    expect_ports("bp_e2", 1, 2);
    set_src(1, 5'd7);
    set_src(2, 5'd8);
    set_src(3, 5'd9);
    tick();
    clr_src();
    expect_ports("bp_e3", 3, 4);
    check("bp_ready_full", src_ready, 4'b1101);
    set_src(1, 5'd11);
    tick();
    expect_ports("bp_e4", 5, 6);
    check("bp_ready_back", src_ready[1], 1);
    tick();
    clr_src();
    expect_ports("bp_e5", 8, 9);
    tick();
    expect_ports("bp_e6", 7, 0);
    tick();
    expect_ports("bp_e7", 11, 0);
    check("bp_busy", busy, 0);
    tick();
    expect_ports("bp_e8", 0, 0);

    // Flush with concurrent pushes (rr_ptr = 2 here).
    for (int i = 0; i < NS; i++) set_src(i, 5'(21 + i));
    tick();
    for (int i = 0; i < NS; i++) set_src(i, 5'(25 + i));
    tick();
    expect_ports("fl_pre", 23, 24);
    check("fl_pre_ready", src_ready, 4'b1100);
    for (int i = 0; i < NS; i++) set_src(i, 5'(29 + i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr_src();
    expect_ports("fl_post", 0, 0);
    check("fl_busy", busy, 0);
    check("fl_ready", src_ready, 4'hF);
    tick();
    expect_ports("fl_discard", 0, 0);

    // Tag 0 is dropped.
    src_valid[2] = 1'b1;
    tick();
    clr_src();
    check("tag0_busy", busy, 0);
    tick();
    expect_ports("tag0_out", 0, 0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < NS; i++) set_src(i, 5'(11 + i));
    tick();
    clr_src();
    tick();
    expect_ports("arst_pre", 11, 12);
    #2;
    rst = 1'b1;
    #1;
    expect_ports("arst_now", 0, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", src_ready, 4'hF);
    #1;
    rst = 1'b0;
    tick();
    expect_ports("arst_after", 0, 0);

    // Random traffic against an outstanding-tag scoreboard.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic was_flush;
      clr_src();
      flush = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 9) < 6) set_src(i, 5'($urandom_range(0, 31)));
      #1;
      for (int k = 0; k < 32; k++) pend[k] = 0;
      for (int i = 0; i < NS; i++)
        if (!flush && src_valid[i] && src_ready[i] && src_roben[i*RW +: RW] != 0)
          pend[src_roben[i*RW +: RW]]++;
      was_flush = flush;
      tick();
      if (was_flush) begin
        check("rnd_flush_r1", cdb_roben1, 0);
        check("rnd_flush_r2", cdb_roben2, 0);
        for (int k = 0; k < 32; k++) outstanding[k] = 0;
      end else begin
        score(cdb_roben1, cdb_data1);
        score(cdb_roben2, cdb_data2);
        for (int k = 0; k < 32; k++) outstanding[k] += pend[k];
      end
    end
    clr_src();
    flush = 1'b0;
    repeat (12) begin
      tick();
      score(cdb_roben1, cdb_data1);
      score(cdb_roben2, cdb_data2);
    end
    begin
      int left;
      left = 0;
      for (int k = 0; k < 32; k++) left += outstanding[k];
      check("rnd_drained", left, 0);
      check("rnd_busy", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
